// File: rtl/cordic_scheduler.sv
// Round-robin front end sharing one pipelined CORDIC unit among NREQ requesters.
// Modes never mix in the pipe; a tag pipe routes each result back to its owner.
module cordic_scheduler #(
  parameter int N         = 16,
  parameter int ITER      = 16,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_mode,
  input  logic [NREQ*N-1:0] req_x,
  input  logic [NREQ*N-1:0] req_y,
  input  logic [NREQ*N-1:0] req_z,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_x,
  output logic [N-1:0]      rsp_y,
  output logic [N-1:0]      rsp_z,
  output logic              cu_start,
  output logic [N-1:0]      cu_xi,
  output logic [N-1:0]      cu_yi,
  output logic [N-1:0]      cu_zi,
  output logic              cu_rot_vec,
  input  logic [N-1:0]      cu_xr,
  input  logic [N-1:0]      cu_yr,
  input  logic [N-1:0]      cu_zr,
  input  logic              cu_done,
  output logic              busy,
  output logic              err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(ITER + 2);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_SWITCH
  } state_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [CW-1:0]   infl_q, infl_d;
  logic [ITER:0]   tv_q;
  logic [PW-1:0]   tt_q [ITER+1];
  logic            start_q, rot_q, err_q;
  logic [N-1:0]    xi_q, yi_q, zi_q;
  logic [N-1:0]    rx_q, ry_q, rz_q;
  logic [NREQ-1:0] rv_q;

  logic [NREQ-1:0]   elig, rot;
  logic [2*NREQ-1:0] dbl;
  logic [PW-1:0]     off, gnt_idx;
  logic [PW:0]       sum;
  logic              opp, gnt_any, to_drain, hs, tail_v;

  assign elig     = req_valid & ~(req_mode ^ {NREQ{mode_q}});
  assign opp      = |(req_valid & (req_mode ^ {NREQ{mode_q}}));
  assign to_drain = opp & (~(|elig) | (burst_q == BW'(MAX_BURST)));
  assign tail_v   = tv_q[ITER];

  // Rotate eligibility so bit 0 is the rr pointer; lowest set bit wins.
  assign dbl = {elig, elig} >> rr_q;
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    gnt_any = 1'b0;
    off     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        gnt_any = 1'b1;
        off     = PW'(i);
      end
    end
  end

  assign sum     = {1'b0, rr_q} + {1'b0, off};
  assign gnt_idx = (sum >= (PW+1)'(NREQ)) ?
                   PW'(sum - (PW+1)'(NREQ)) : sum[PW-1:0];

  assign hs        = (state_q == S_RUN) & gnt_any & ~to_drain;
  assign req_ready = hs ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_RUN:    if (to_drain) state_d = S_DRAIN;
      S_DRAIN:  if (infl_q == '0 && !start_q) state_d = S_SWITCH;
      S_SWITCH: begin
        mode_d  = ~mode_q;
        state_d = S_RUN;
      end
      default:  state_d = S_RUN;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (hs) rr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
    burst_d = burst_q;
    if (state_q == S_SWITCH || !opp) burst_d = '0;
    else if (hs) burst_d = burst_q + BW'(1);
    infl_d = infl_q;
    unique case ({hs, tail_v})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      mode_q  <= 1'b0;
      rr_q    <= '0;
      burst_q <= '0;
      infl_q  <= '0;
      tv_q    <= '0;
      for (int i = 0; i <= ITER; i++) tt_q[i] <= '0;
      start_q <= 1'b0;
      rot_q   <= 1'b0;
      err_q   <= 1'b0;
      xi_q    <= '0;
      yi_q    <= '0;
      zi_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      rz_q    <= '0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      infl_q  <= infl_d;
      start_q <= hs;
      rot_q   <= mode_q;
      if (hs) begin
        xi_q <= req_x[gnt_idx*N +: N];
        yi_q <= req_y[gnt_idx*N +: N];
        zi_q <= req_z[gnt_idx*N +: N];
      end
      // Tail of the tag pipe lines up with cu_done.
      tv_q    <= {tv_q[ITER-1:0], hs};
      tt_q[0] <= gnt_idx;
      for (int i = 1; i <= ITER; i++) tt_q[i] <= tt_q[i-1];
      rv_q <= (cu_done & tail_v) ? (NREQ'(1) << tt_q[ITER]) : '0;
      if (cu_done) begin
        rx_q <= cu_xr;
        ry_q <= cu_yr;
        rz_q <= cu_zr;
      end
      if (cu_done != tail_v) err_q <= 1'b1;
    end
  end

  assign rsp_valid  = rv_q;
  assign rsp_x      = rx_q;
  assign rsp_y      = ry_q;
  assign rsp_z      = rz_q;
  assign cu_start   = start_q;
  assign cu_xi      = xi_q;
  assign cu_yi      = yi_q;
  assign cu_zi      = zi_q;
  assign cu_rot_vec = rot_q;
  assign busy       = (infl_q != '0) | start_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: behavioural CORDIC unit, issue-side scoreboard push,
// response monitor pop/compare, plus directed arbitration and mode-switch checks.
module tb_cordic_scheduler;

  localparam int N    = 16;
  localparam int ITER = 16;
  localparam int NREQ = 4;
  localparam int MB   = 8;
  localparam real PI  = 3.14159265358979;
  localparam real KG  = 1.6467602581;

  logic              clk, rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, req_mode, rsp_valid;
  logic [NREQ*N-1:0] req_x, req_y, req_z;
  logic [N-1:0]      rsp_x, rsp_y, rsp_z;
  logic              cu_start, cu_rot_vec, cu_done, busy, err, inj;
  logic [N-1:0]      cu_xi, cu_yi, cu_zi, cu_xr, cu_yr, cu_zr;

  cordic_scheduler #(.N(N), .ITER(ITER), .NREQ(NREQ), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .cu_start(cu_start), .cu_xi(cu_xi), .cu_yi(cu_yi), .cu_zi(cu_zi),
    .cu_rot_vec(cu_rot_vec), .cu_xr(cu_xr), .cu_yr(cu_yr), .cu_zr(cu_zr),
    .cu_done(cu_done), .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] rnd(input real r);
    int i;
    i = $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
    return N'(i);
  endfunction

  // Ideal CORDIC result; angle units: 32768 = pi.
  function automatic logic [3*N-1:0] unit_fn(input logic [N-1:0] x, y, z, input logic m);
    real xr, yr, zr, xo, yo, zo;
    xr = $itor($signed(x));
    yr = $itor($signed(y));
    zr = $itor($signed(z)) * PI / 32768.0;
    if (!m) begin
      xo = KG * (xr * $cos(zr) - yr * $sin(zr));
      yo = KG * (xr * $sin(zr) + yr * $cos(zr));
      zo = 0.0;
    end else begin
      xo = KG * $sqrt(xr * xr + yr * yr);
      yo = 0.0;
      zo = (zr + $atan2(yr, xr)) * 32768.0 / PI;
    end
    return {rnd(xo), rnd(yo), rnd(zo)};
  endfunction

  logic [ITER-1:0]  upv;
  logic [3*N-1:0]   ud [ITER];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) upv <= '0;
    else begin
      upv   <= {upv[ITER-2:0], cu_start};
      ud[0] <= unit_fn(cu_xi, cu_yi, cu_zi, cu_rot_vec);
      for (int i = 1; i < ITER; i++) ud[i] <= ud[i-1];
    end
  end
  assign cu_done = upv[ITER-1] | inj;
  assign {cu_xr, cu_yr, cu_zr} = ud[ITER-1];

  typedef struct {
    logic [NREQ-1:0] oh;
    logic [3*N-1:0]  d;
    int              due;
  } exp_t;

  exp_t sb[$];
  int   log_idx[$];
  int   log_cyc[$];
  int   total = 0, bad = 0, rsp_cnt = 0, last_rsp_cyc = 0;
  logic [NREQ-1:0] last_oh;
  logic [N-1:0]    last_x, last_y;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d+/-%0d", nm, act, exp, tol);
    end
  endtask

  task automatic set_op(input int k, input logic [N-1:0] x, y, z);
    req_x[k*N +: N] = x;
    req_y[k*N +: N] = y;
    req_z[k*N +: N] = z;
  endtask

  // Issue side: push expected result for every handshake seen.
  initial forever begin
    @(negedge clk);
    if (rst_n && req_ready != '0) begin
      chk("ready_onehot", $countones(req_ready), 1);
      for (int k = 0; k < NREQ; k++) begin
        if (req_ready[k] && req_valid[k]) begin
          exp_t e;
          e.oh  = NREQ'(1) << k;
          e.d   = unit_fn(req_x[k*N +: N], req_y[k*N +: N], req_z[k*N +: N], req_mode[k]);
          e.due = cyc + ITER + 2;
          sb.push_back(e);
          log_idx.push_back(k);
          log_cyc.push_back(cyc);
        end
      end
    end
  end

  // Response side: pop and compare.
  initial forever begin
    @(negedge clk);
    if (rst_n && rsp_valid != '0) begin
      rsp_cnt++;
      last_oh      = rsp_valid;
      last_x       = rsp_x;
      last_y       = rsp_y;
      last_rsp_cyc = cyc;
      if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_onehot", rsp_valid, e.oh);
        chk("rsp_data", {rsp_x, rsp_y, rsp_z}, e.d);
        chk("rsp_latency", cyc, e.due);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 200, 1);
  endtask

  task automatic issue_one(input int k, input logic m, input logic [N-1:0] x, y, z);
    int n = 0;
    @(posedge clk); #1;
    set_op(k, x, y, z);
    req_mode[k]  = m;
    req_valid[k] = 1'b1;
    @(negedge clk);
    while (!req_ready[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("issue_timeout", n < 100, 1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  initial begin
    int n, n0;
    rst_n = 1'b0; inj = 1'b0;
    req_valid = '0; req_mode = '0;
    req_x = '0; req_y = '0; req_z = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cu_start", cu_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rot_vec", cu_rot_vec, 0);
    chk("rst_cu_xi", cu_xi, 0);

    // Round robin, all four requesting mode 0.
    log_idx.delete(); log_cyc.delete();
    for (int k = 0; k < NREQ; k++)
      set_op(k, N'(16'h1000 + k * 16'h200), N'(k * 16'h100), N'(k * 16'h300));
    @(posedge clk); #1;
    req_mode = '0; req_valid = '1;
    repeat (8) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("rr_busy", busy, 1);
    wait_drain();
    chk("rr_count", log_idx.size(), 8);
    for (int i = 0; i < log_idx.size(); i++) begin
      chk("rr_grant", log_idx[i], i % 4);
      chk("rr_cycle", log_cyc[i] - log_cyc[0], i);
    end

    // Single rotation: (0x4000,0) by pi/4 -> K*16384*0.7071 = 19078.
    issue_one(0, 1'b0, 16'h4000, 16'h0000, 16'h2000);
    wait_drain();
    chk("single_oh", last_oh, 4'b0001);
    chk_tol("single_x", int'($signed(last_x)), 19078, 2);
    chk_tol("single_y", int'($signed(last_y)), 19078, 2);

    // Mode switch: three mode-0 ops, then req1 in mode 1.
    log_idx.delete(); log_cyc.delete();
    @(posedge clk); #1;
    set_op(0, 16'h0c00, 16'h0400, 16'h1000);
    req_mode = '0; req_valid = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    set_op(1, 16'h1800, 16'h0800, 16'h0000);
    req_mode = 4'b0010; req_valid = 4'b0010;
    n = 0;
    @(negedge clk);
    while (!req_ready[1] && n < 100) begin
      chk("drain_ready", req_ready, 0);
      @(negedge clk);
      n++;
    end
    chk("switch_timeout", n < 100, 1);
    chk("switch_gap", cyc - last_rsp_cyc, 2);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("switch_start", cu_start, 1);
    chk("switch_rot_vec", cu_rot_vec, 1);
    wait_drain();
    chk("switch_log", log_idx.size(), 4);
    if (log_idx.size() == 4) chk("switch_who", log_idx[3], 1);

    issue_one(3, 1'b0, 16'h0800, 16'h0200, 16'h0100);
    wait_drain();

    // Burst limit: req0 mode 0 streams while req2 mode 1 waits.
    log_idx.delete(); log_cyc.delete();
    @(posedge clk); #1;
    set_op(0, 16'h0a00, 16'h0100, 16'h0800);
    set_op(2, 16'h1200, 16'hf800, 16'h0000);
    req_mode = 4'b0100; req_valid = 4'b0101;
    n = 0;
    @(negedge clk);
    while (!req_ready[2] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("burst_timeout", n < 200, 1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("burst_count", log_idx.size(), 9);
    for (int i = 0; i < log_idx.size(); i++)
      chk("burst_grant", log_idx[i], (i < 8) ? 0 : 2);
    if (log_idx.size() >= 8) chk("burst_span", log_cyc[7] - log_cyc[0], 7);
    wait_drain();

    // Reset with five ops in flight.
    @(posedge clk); #1;
    req_mode = '1; req_valid = '1;
    repeat (5) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #3 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_cu_start", cu_start, 0);
    chk("ar_busy", busy, 0);
    chk("ar_rot_vec", cu_rot_vec, 0);
    chk("ar_cu_xi", cu_xi, 0);
    chk("ar_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = rsp_cnt;
    repeat (ITER + 6) @(negedge clk);
    chk("post_reset_rsp", rsp_cnt - n0, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_err", err, 0);

    // Spurious cu_done with an empty tag pipe.
    @(posedge clk); #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    @(negedge clk);
    chk("err_set", err, 1);
    repeat (5) @(negedge clk);
    chk("err_sticky", err, 1);
    chk("fault_no_rsp", rsp_cnt - n0, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
